// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg
//   Shared types for the write-back arbiter slice.
//   - WB_ADDR_WIDTH / WB_DATA_WIDTH : default register address / data widths
//   - NUM_TOT_WORDS                 : number of architectural registers (int + FP)
//   - wb_src_e                      : which source drives a write port
//   - wb_req_t                      : one register-file write request
package riscv_wb_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 6;
    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned NUM_TOT_WORDS = 2**WB_ADDR_WIDTH;

    typedef enum logic [2:0] {
        WB_SRC_NONE,
        WB_SRC_EX,
        WB_SRC_LSU,
        WB_SRC_SKID,
        WB_SRC_APU
    } wb_src_e;

    typedef struct packed {
        logic                     we;
        logic [WB_ADDR_WIDTH-1:0] waddr;
        logic [WB_DATA_WIDTH-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/riscv_wb_skid_buffer.sv
// riscv_wb_skid_buffer
//   One-entry holding register for APU results that found no free write port.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (discards the entry)
//     push_i      : capture push_req_i (only issued while empty)
//     push_req_i  : request to capture
//     pop_i       : entry consumed this cycle (only issued while full)
//     full_o      : entry valid
//     entry_o     : stored request
module riscv_wb_skid_buffer
    import riscv_wb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  wb_req_t push_req_i,
    input  logic    pop_i,
    output logic    full_o,
    output wb_req_t entry_o
);

    logic    r_full;
    wb_req_t r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (push_i) begin
            r_full  <= 1'b1;
            r_entry <= push_req_i;
        end else if (pop_i) begin
            r_full  <= 1'b0;
        end
    end

    assign full_o  = r_full;
    assign entry_o = r_entry;

endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
//   Merges EX, LSU and APU results onto register-file write ports A and B,
//   holds an APU result in a one-entry skid when both ports are busy, and
//   keeps a per-register pending scoreboard that drives the decode stall.
//   Ports:
//     ex_*        : EX result (always accepted)
//     lsu_*       : load result (always accepted)
//     apu_*       : APU result, valid/ready handshake
//     issue_*     : long-latency op issued, marks destination pending
//     rden_i, raddr_{a,b,c}_i, dec_we_i, dec_waddr_i : decode operands
//     hazard_o    : decode stall
//     we/waddr/wdata_{a,b}_o : register-file write ports (B wins on equal addr)
//     pending_o   : scoreboard state
module riscv_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_we_i,
    input  logic [ADDR_WIDTH-1:0]   ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]   ex_wdata_i,
    input  logic                    lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    input  logic                    apu_valid_i,
    input  logic [ADDR_WIDTH-1:0]   apu_waddr_i,
    input  logic [DATA_WIDTH-1:0]   apu_wdata_i,
    output logic                    apu_ready_o,
    input  logic                    issue_i,
    input  logic [ADDR_WIDTH-1:0]   issue_waddr_i,
    input  logic [2:0]              rden_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_b_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_c_i,
    input  logic                    dec_we_i,
    input  logic [ADDR_WIDTH-1:0]   dec_waddr_i,
    output logic                    hazard_o,
    output logic                    we_a_o,
    output logic [ADDR_WIDTH-1:0]   waddr_a_o,
    output logic [DATA_WIDTH-1:0]   wdata_a_o,
    output logic                    we_b_o,
    output logic [ADDR_WIDTH-1:0]   waddr_b_o,
    output logic [DATA_WIDTH-1:0]   wdata_b_o,
    output logic [2**ADDR_WIDTH-1:0] pending_o
);

    localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;

    logic [NUM_WORDS-1:0]  r_pending;
    logic [NUM_WORDS-1:0]  w_set;
    logic [NUM_WORDS-1:0]  w_clr;

    logic                  w_skid_full;
    wb_req_t               w_skid_entry;
    wb_req_t               w_push_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_apu_acc;

    // The single APU-side candidate: the skid entry when present, otherwise
    // the live APU result (only accepted while the skid is empty).
    logic                  w_cand_v;
    wb_src_e               w_cand_src;
    logic [ADDR_WIDTH-1:0] w_cand_addr;
    logic [DATA_WIDTH-1:0] w_cand_data;

    wb_src_e               w_src_a;
    wb_src_e               w_src_b;
    logic [ADDR_WIDTH-1:0] w_addr_a;
    logic [DATA_WIDTH-1:0] w_data_a;
    logic [ADDR_WIDTH-1:0] w_addr_b;
    logic [DATA_WIDTH-1:0] w_data_b;

    assign w_push_req = '{we: 1'b1, waddr: apu_waddr_i, wdata: apu_wdata_i};

    riscv_wb_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (w_push),
        .push_req_i (w_push_req),
        .pop_i      (w_pop),
        .full_o     (w_skid_full),
        .entry_o    (w_skid_entry)
    );

    assign apu_ready_o = !w_skid_full;
    assign w_apu_acc   = apu_valid_i & !w_skid_full;

    always_comb begin
        w_cand_v    = 1'b0;
        w_cand_src  = WB_SRC_NONE;
        w_cand_addr = '0;
        w_cand_data = '0;
        if (w_skid_full && w_skid_entry.we) begin
            w_cand_v    = 1'b1;
            w_cand_src  = WB_SRC_SKID;
            w_cand_addr = w_skid_entry.waddr;
            w_cand_data = w_skid_entry.wdata;
        end else if (w_apu_acc) begin
            w_cand_v    = 1'b1;
            w_cand_src  = WB_SRC_APU;
            w_cand_addr = apu_waddr_i;
            w_cand_data = apu_wdata_i;
        end
    end

    always_comb begin
        w_src_a  = WB_SRC_NONE;
        w_src_b  = WB_SRC_NONE;
        w_addr_a = '0;
        w_data_a = '0;
        w_addr_b = '0;
        w_data_b = '0;
        if (ex_we_i) begin
            w_src_a  = WB_SRC_EX;
            w_addr_a = ex_waddr_i;
            w_data_a = ex_wdata_i;
        end else if (w_cand_v) begin
            w_src_a  = w_cand_src;
            w_addr_a = w_cand_addr;
            w_data_a = w_cand_data;
        end
        if (lsu_valid_i) begin
            w_src_b  = WB_SRC_LSU;
            w_addr_b = lsu_waddr_i;
            w_data_b = lsu_wdata_i;
        end else if (w_cand_v && w_src_a != w_cand_src) begin
            w_src_b  = w_cand_src;
            w_addr_b = w_cand_addr;
            w_data_b = w_cand_data;
        end
    end

    // Candidate left over only when EX and LSU both write; a live APU result
    // then goes into the skid, a skid entry simply stays.
    assign w_pop  = w_skid_full && (w_src_a == WB_SRC_SKID || w_src_b == WB_SRC_SKID);
    assign w_push = w_apu_acc && w_src_a != WB_SRC_APU && w_src_b != WB_SRC_APU;

    // Writes to register 0 are consumed but never reach the register file.
    always_comb begin
        we_a_o    = (w_src_a != WB_SRC_NONE) && (w_addr_a != '0);
        we_b_o    = (w_src_b != WB_SRC_NONE) && (w_addr_b != '0);
        waddr_a_o = we_a_o ? w_addr_a : '0;
        wdata_a_o = we_a_o ? w_data_a : '0;
        waddr_b_o = we_b_o ? w_addr_b : '0;
        wdata_b_o = we_b_o ? w_data_b : '0;
    end

    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (we_a_o && (w_src_a == WB_SRC_SKID || w_src_a == WB_SRC_APU))
            w_clr[waddr_a_o] = 1'b1;
        if (we_b_o && w_src_b != WB_SRC_EX)
            w_clr[waddr_b_o] = 1'b1;
        if (issue_i && issue_waddr_i != '0)
            w_set[issue_waddr_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr) | w_set;
    end

    assign pending_o = r_pending;

    function automatic logic busy(input logic [ADDR_WIDTH-1:0] a,
                                  input logic [NUM_WORDS-1:0]  pend,
                                  input logic                  wa,
                                  input logic [ADDR_WIDTH-1:0] aa,
                                  input logic                  wb,
                                  input logic [ADDR_WIDTH-1:0] ab);
        return pend[a] | (wa && aa == a) | (wb && ab == a);
    endfunction

    assign hazard_o =
        (rden_i[0] && busy(raddr_a_i,   r_pending, we_a_o, waddr_a_o, we_b_o, waddr_b_o)) ||
        (rden_i[1] && busy(raddr_b_i,   r_pending, we_a_o, waddr_a_o, we_b_o, waddr_b_o)) ||
        (rden_i[2] && busy(raddr_c_i,   r_pending, we_a_o, waddr_a_o, we_b_o, waddr_b_o)) ||
        (dec_we_i  && busy(dec_waddr_i, r_pending, we_a_o, waddr_a_o, we_b_o, waddr_b_o));

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
module tb_riscv_wb_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk, rst_n;
    logic          ex_we_i;
    logic [AW-1:0] ex_waddr_i;
    logic [DW-1:0] ex_wdata_i;
    logic          lsu_valid_i;
    logic [AW-1:0] lsu_waddr_i;
    logic [DW-1:0] lsu_wdata_i;
    logic          apu_valid_i;
    logic [AW-1:0] apu_waddr_i;
    logic [DW-1:0] apu_wdata_i;
    logic          apu_ready_o;
    logic          issue_i;
    logic [AW-1:0] issue_waddr_i;
    logic [2:0]    rden_i;
    logic [AW-1:0] raddr_a_i, raddr_b_i, raddr_c_i;
    logic          dec_we_i;
    logic [AW-1:0] dec_waddr_i;
    logic          hazard_o;
    logic          we_a_o, we_b_o;
    logic [AW-1:0] waddr_a_o, waddr_b_o;
    logic [DW-1:0] wdata_a_o, wdata_b_o;
    logic [63:0]   pending_o;

    riscv_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .apu_valid_i(apu_valid_i), .apu_waddr_i(apu_waddr_i), .apu_wdata_i(apu_wdata_i),
        .apu_ready_o(apu_ready_o),
        .issue_i(issue_i), .issue_waddr_i(issue_waddr_i),
        .rden_i(rden_i), .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
        .dec_we_i(dec_we_i), .dec_waddr_i(dec_waddr_i),
        .hazard_o(hazard_o),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
        .pending_o(pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a set of pending registers and an optional parked APU result.
    logic [63:0]   m_pend, n_pend;
    logic          m_sv, n_sv;
    logic [AW-1:0] m_sa, n_sa;
    logic [DW-1:0] m_sd, n_sd;
    logic          e_wea, e_web, e_rdy, e_hz;
    logic [AW-1:0] e_aa, e_ab;
    logic [DW-1:0] e_da, e_db;

    task automatic model_reset();
        m_pend = '0; m_sv = 1'b0; m_sa = '0; m_sd = '0;
    endtask

    function automatic logic m_busy(input logic [AW-1:0] a);
        return m_pend[a] || (e_wea && e_aa == a) || (e_web && e_ab == a);
    endfunction

    // Settle, compute what the ports must show this cycle, compare everything.
    task automatic eval();
        logic          cv, clive, used, a_v, b_v, a_l, b_l;
        logic [AW-1:0] ca, a_a, b_a;
        logic [DW-1:0] cd, a_d, b_d;
        #2;
        e_rdy = !m_sv;
        cv = 0; clive = 0; ca = '0; cd = '0; used = 0;
        if (m_sv) begin cv = 1; ca = m_sa; cd = m_sd; end
        else if (apu_valid_i) begin cv = 1; clive = 1; ca = apu_waddr_i; cd = apu_wdata_i; end
        a_v = 0; a_l = 0; a_a = '0; a_d = '0;
        b_v = 0; b_l = 0; b_a = '0; b_d = '0;
        if (ex_we_i) begin a_v = 1; a_a = ex_waddr_i; a_d = ex_wdata_i; end
        else if (cv) begin a_v = 1; a_l = 1; a_a = ca; a_d = cd; used = 1; end
        if (lsu_valid_i) begin b_v = 1; b_l = 1; b_a = lsu_waddr_i; b_d = lsu_wdata_i; end
        else if (cv && !used) begin b_v = 1; b_l = 1; b_a = ca; b_d = cd; used = 1; end
        e_wea = a_v && a_a != 0; e_aa = e_wea ? a_a : '0; e_da = e_wea ? a_d : '0;
        e_web = b_v && b_a != 0; e_ab = e_web ? b_a : '0; e_db = e_web ? b_d : '0;
        n_sv = m_sv; n_sa = m_sa; n_sd = m_sd;
        if (m_sv && used) n_sv = 0;
        if (clive && !used) begin n_sv = 1; n_sa = ca; n_sd = cd; end
        n_pend = m_pend;
        if (e_wea && a_l) n_pend[e_aa] = 1'b0;
        if (e_web && b_l) n_pend[e_ab] = 1'b0;
        if (issue_i && issue_waddr_i != 0) n_pend[issue_waddr_i] = 1'b1;
        e_hz = (rden_i[0] && m_busy(raddr_a_i)) || (rden_i[1] && m_busy(raddr_b_i)) ||
               (rden_i[2] && m_busy(raddr_c_i)) || (dec_we_i && m_busy(dec_waddr_i));
        chk("we_a",    we_a_o,    e_wea);
        chk("waddr_a", waddr_a_o, e_aa);
        chk("wdata_a", wdata_a_o, e_da);
        chk("we_b",    we_b_o,    e_web);
        chk("waddr_b", waddr_b_o, e_ab);
        chk("wdata_b", wdata_b_o, e_db);
        chk("ready",   apu_ready_o, e_rdy);
        chk("hazard",  hazard_o,  e_hz);
        chk("pending", pending_o, m_pend);
    endtask

    task automatic adv();
        m_pend = n_pend; m_sv = n_sv; m_sa = n_sa; m_sd = n_sd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_we_i = 0; ex_waddr_i = '0; ex_wdata_i = '0;
        lsu_valid_i = 0; lsu_waddr_i = '0; lsu_wdata_i = '0;
        apu_valid_i = 0; apu_waddr_i = '0; apu_wdata_i = '0;
        issue_i = 0; issue_waddr_i = '0;
        rden_i = '0; raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
        dec_we_i = 0; dec_waddr_i = '0;
    endtask

    task automatic set_ex(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ex_we_i = 1; ex_waddr_i = a; ex_wdata_i = d;
    endtask
    task automatic set_lsu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        lsu_valid_i = 1; lsu_waddr_i = a; lsu_wdata_i = d;
    endtask
    task automatic set_apu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        apu_valid_i = 1; apu_waddr_i = a; apu_wdata_i = d;
    endtask

    initial begin
        logic hold;
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        eval();
        chk("rst_pending", pending_o, 64'h0);
        chk("rst_ready",   apu_ready_o, 1);
        chk("rst_we_a",    we_a_o, 0);
        chk("rst_we_b",    we_b_o, 0);
        chk("rst_hazard",  hazard_o, 0);
        adv();

        // EX + APU, no LSU: APU goes out on B
        set_ex(3, 32'h11); set_apu(34, 32'h22);
        eval();
        chk("t2_waddr_a", waddr_a_o, 3);  chk("t2_wdata_a", wdata_a_o, 32'h11);
        chk("t2_we_b",    we_b_o, 1);
        chk("t2_waddr_b", waddr_b_o, 34); chk("t2_wdata_b", wdata_b_o, 32'h22);
        chk("t2_ready",   apu_ready_o, 1);
        adv(); idle();

        // EX + LSU + APU: APU parked, drains on A next cycle
        set_ex(3, 32'h33); set_lsu(4, 32'h44); set_apu(40, 32'hAB);
        eval();
        chk("t3_waddr_a", waddr_a_o, 3); chk("t3_waddr_b", waddr_b_o, 4);
        chk("t3_ready0",  apu_ready_o, 1);
        adv(); idle();
        eval();
        chk("t3_ready1",  apu_ready_o, 0);
        chk("t3_we_a",    we_a_o, 1);
        chk("t3_waddr_a2", waddr_a_o, 40); chk("t3_wdata_a2", wdata_a_o, 32'hAB);
        chk("t3_we_b",    we_b_o, 0);
        adv();
        eval();
        chk("t3_ready2",  apu_ready_o, 1);
        chk("t3_we_a3",   we_a_o, 0);
        adv();

        // RAW stall on x7 until the load writes it
        issue_i = 1; issue_waddr_i = 7;
        eval();
        chk("t4_pend_pre", pending_o[7], 0);
        adv(); idle();
        rden_i = 3'b010; raddr_b_i = 7;
        eval();
        chk("t4_hz1", hazard_o, 1); chk("t4_pend7", pending_o[7], 1);
        adv();
        eval();
        chk("t4_hz2", hazard_o, 1);
        adv();
        set_lsu(7, 32'h77);
        eval();
        chk("t4_hz_wr", hazard_o, 1); chk("t4_waddr_b", waddr_b_o, 7);
        adv();
        lsu_valid_i = 0;
        eval();
        chk("t4_hz_rel", hazard_o, 0); chk("t4_pend_clr", pending_o[7], 0);
        adv(); idle();

        // Set wins over clear on x9
        issue_i = 1; issue_waddr_i = 9;
        eval(); adv();
        set_lsu(9, 32'h99);
        eval();
        chk("t5_we_b", we_b_o, 1);
        adv(); idle();
        eval();
        chk("t5_pend9", pending_o[9], 1);
        adv();

        // Register 0: write dropped, issue ignored
        set_ex(0, 32'hFFFF); issue_i = 1; issue_waddr_i = 0;
        eval();
        chk("t6_we_a", we_a_o, 0);
        adv(); idle();
        eval();
        chk("t6_pend0", pending_o[0], 0);
        adv();

        // Asynchronous reset with the skid full and pending[5] set
        issue_i = 1; issue_waddr_i = 5;
        eval(); adv(); idle();
        set_ex(3, 32'h1); set_lsu(4, 32'h2); set_apu(40, 32'hCD);
        eval(); adv(); idle();
        eval();
        chk("t7_ready_full", apu_ready_o, 0);
        chk("t7_pend5",      pending_o[5], 1);
        #1 rst_n = 0;
        model_reset();
        eval();
        chk("t7_pending", pending_o, 64'h0);
        chk("t7_ready",   apu_ready_o, 1);
        chk("t7_we_a",    we_a_o, 0);
        chk("t7_we_b",    we_b_o, 0);
        #1 rst_n = 1;
        adv();
        eval();
        chk("t7_skid_gone", we_a_o, 0);
        adv();

        // Randomized phase; small address range to provoke hazards and collisions
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            ex_we_i = ($urandom_range(0, 1) == 1);
            ex_waddr_i = AW'($urandom_range(0, 15)); ex_wdata_i = $urandom;
            lsu_valid_i = ($urandom_range(0, 1) == 1);
            lsu_waddr_i = AW'($urandom_range(0, 15)); lsu_wdata_i = $urandom;
            if (!hold) begin
                apu_valid_i = ($urandom_range(0, 1) == 1);
                apu_waddr_i = AW'($urandom_range(0, 15)); apu_wdata_i = $urandom;
            end
            issue_i = ($urandom_range(0, 3) == 0);
            issue_waddr_i = AW'($urandom_range(0, 15));
            rden_i = 3'($urandom_range(0, 7));
            raddr_a_i = AW'($urandom_range(0, 15));
            raddr_b_i = AW'($urandom_range(0, 15));
            raddr_c_i = AW'($urandom_range(0, 15));
            dec_we_i = ($urandom_range(0, 1) == 1);
            dec_waddr_i = AW'($urandom_range(0, 15));
            eval();
            hold = apu_valid_i && !e_rdy;
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_wb_arbiter.md
# riscv_wb_arbiter

Write-back arbiter and register scoreboard that sits directly upstream of the latch-based register file's two write ports. It merges three result sources onto write ports A and B: EX single-cycle results, LSU load data, and APU/FPU multi-cycle results. A one-entry skid buffer holds APU results when no port is free. A per-register pending scoreboard raises a decode stall for RAW and WAW hazards against outstanding long-latency writes.

## Interface
- ADDR_WIDTH, 6: register address width; 6 covers 32 integer plus 32 FP registers.
- DATA_WIDTH, 32: result width.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_we_i / ex_waddr_i / ex_wdata_i  in  1/ADDR_WIDTH/DATA_WIDTH  EX result; always accepted.
- lsu_valid_i / lsu_waddr_i / lsu_wdata_i  in  1/ADDR_WIDTH/DATA_WIDTH  load result; always accepted.
- apu_valid_i / apu_waddr_i / apu_wdata_i  in  1/ADDR_WIDTH/DATA_WIDTH  APU result.
- apu_ready_o  out  1  APU result accepted when valid & ready.
- issue_i / issue_waddr_i  in  1/ADDR_WIDTH  long-latency op (load or APU) issued; marks its destination pending.
- rden_i  in  3  per-read-port enable from decode.
- raddr_a_i / raddr_b_i / raddr_c_i  in  ADDR_WIDTH  decode read addresses.
- dec_we_i / dec_waddr_i  in  1/ADDR_WIDTH  decode destination, checked for WAW.
- hazard_o  out  1  decode stall.
- we_a_o / waddr_a_o / wdata_a_o  out  1/ADDR_WIDTH/DATA_WIDTH  register file write port A.
- we_b_o / waddr_b_o / wdata_b_o  out  1/ADDR_WIDTH/DATA_WIDTH  register file write port B; B wins over A on equal addresses.
- pending_o  out  2**ADDR_WIDTH  scoreboard state, for debug and trace.

## Operation
- Port A priority: EX, then skid entry, then live APU.
- Port B priority: LSU, then skid entry, then live APU.
- The skid entry always drains before the live APU result; the two never go out in the same cycle.
- An accepted APU result that finds no free port is captured in the skid. This happens only when EX and LSU write in the same cycle and the skid is empty.
- apu_ready_o = !skid_full. It is derived from state only, with no combinational path from apu_valid_i.
- Writes to address 0 are dropped: the source is consumed, and we_x_o stays low.
- Scoreboard:
  - pending[r] sets at the edge after issue_i with issue_waddr_i = r.
  - pending[r] clears at the edge ending the cycle in which an LSU or APU write to r appears on either port.
  - EX writes never clear pending.
  - Set and clear of the same r in the same cycle: set wins.
  - Issue to address 0 is ignored.
- hazard_o is asserted when either of the following is pending, or is being written on A or B in the current cycle:
  - any enabled raddr (rden_i bit 0/1/2 for a/b/c), or
  - dec_waddr_i when dec_we_i is high.
- Same-address writes from two sources in one cycle are prevented by the scoreboard stall, so no ordering logic is required.
- Reset (asynchronous, any time):
  - pending all 0 and skid empty; an in-flight skid entry is discarded.
  - apu_ready_o = 1; hazard_o = 0 with idle inputs.
  - we_a_o = we_b_o = 0, waddr and wdata outputs = 0.

## Timing
- Write ports are combinational from source inputs and skid state, giving 0-cycle latency. The register file samples at the next rising edge.
- An APU result captured in the skid appears on a port at the earliest one cycle later.
- apu_ready_o drops the cycle after capture and rises the cycle after the skid drains.
- hazard_o is combinational from decode inputs, pending, and current port outputs.
- A pending bit is visible on hazard_o the cycle after issue. A stall on a written register lasts through the write cycle and releases the following cycle.

## Structure
- Package riscv_wb_pkg holds:
  - localparam NUM_TOT_WORDS = 2**ADDR_WIDTH;
  - enum wb_src_e: WB_SRC_NONE, WB_SRC_EX, WB_SRC_LSU, WB_SRC_SKID, WB_SRC_APU;
  - struct wb_req_t {we, waddr, wdata}.
- Sub-module riscv_wb_skid_buffer: one wb_req_t entry with a full flag, and push/pop ports.
- Scoreboard, port muxes, and hazard logic live in the top module.

## Test plan
- Reset mid-operation: skid full and pending[5] set, pulse rst_n low → skid empty, pending_o = 0, apu_ready_o = 1, we_a_o = we_b_o = 0.
- EX x3 = 0x11 and APU f2 (addr 34) = 0x22 in the same cycle, no LSU → A = (3, 0x11), B = (34, 0x22), apu_ready_o stays 1.
- EX x3, LSU x4, APU addr 40 = 0xAB in one cycle → APU result captured; next cycle apu_ready_o = 0 and A = (40, 0xAB) with EX idle; the cycle after, ready = 1.
- issue_i with waddr 7; next cycle raddr_b_i = 7, rden_i = 3'b010 → hazard_o = 1 until the LSU write of x7 appears, then 0 the following cycle; pending[7] clears.
- issue x9 while the LSU writes x9 in the same cycle → pending[9] = 1 afterwards (set wins).
- EX write to x0 = 0xFFFF → we_a_o = 0; issue to 0 → pending_o[0] stays 0.
